id_ex_stage: RTL
================

# id_ex_stage

Parametrised ID→EX pipeline stage for the multithreaded CPU. It carries operand data, packed control and thread ID from decode to execute under a valid/ready handshake, so either side can stall without losing or duplicating an instruction. It supports per-thread squash on a taken branch and zeroes control on every bubble. A compile-time option selects between a full-throughput two-entry skid buffer and a single register.

## Interface
- DATA_W, default 64: width of each operand.
- CTRL_W, default 26: packed control, {br_ctrl[1:0], dest[4:0], br_addr[9:0], alu_ctrl[5:0], mem_ctrl, wb_ctrl[1:0]}, MSB first; wb_ctrl occupies bits [1:0].
- TID_W, default 2: thread ID width.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_data0, in_data1  in  DATA_W  operands
- in_ctrl  in  CTRL_W  packed control
- in_tid  in  TID_W  thread of incoming instruction
- out_valid  out  1  execute-side instruction present
- out_ready  in  1  execute consumes this cycle
- out_data0, out_data1  out  DATA_W  registered operands
- out_ctrl  out  CTRL_W  registered control
- out_tid  out  TID_W  registered thread
- flush_valid  in  1  squash request
- flush_tid  in  TID_W  thread to squash

## Operation
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Storage is a main register, which drives the out_* ports, plus a skid register that exists only when ID_EX_STAGE_SKID_EN is defined. Each register has a valid bit.
- Next-state computation, in order:
  1. If main is empty or its output transfer occurs, main takes the skid entry if one is valid, otherwise the input. An input arriving in the same cycle as a skid promotion goes into skid.
  2. If main is held and an input transfer occurs, the input goes into skid.
  3. Squash: when flush_valid is high, every next-state entry whose tid equals flush_tid is invalidated. This includes an input accepted in the same cycle.
  4. If main is invalid after the squash and skid is valid, skid is promoted into main.
- Invalid entries always hold zero data, zero ctrl and zero tid. A bubble therefore has mem_ctrl = 0 and wb_ctrl = 0.
- The out_* fields are 0 whenever out_valid = 0.
- Ordering within a thread and across threads is strict FIFO. There is no reordering.
- Squash with flush_tid matching no held entry has no effect.
- in_ready is forced to 0 while reset is high. All inputs are ignored during reset.

## Timing
- Latency: an input accepted at edge N appears on out_* after edge N. This is one cycle with no combinational path from in_* to out_*.
- Reset: out_valid = 0, out_data0/1 = 0, out_ctrl = 0, out_tid = 0, and skid is emptied. in_ready = 1 on the first cycle after reset deasserts.
- Skid build: in_ready = !skid_valid. This is purely registered, with no combinational path from out_ready.
- Sustained throughput is one instruction per cycle while out_ready = 1.
- Flush takes effect at the next edge. A squashed entry is never presented with out_valid = 1 after that edge. The current cycle's output transfer, if one occurs, still completes.
- Reset asserted mid-stall discards both entries at the next edge.

## Configuration
- ID_EX_STAGE_SKID_EN defined: two-entry skid buffer with registered in_ready, as described above.
- ID_EX_STAGE_SKID_EN undefined: single main register with in_ready = !out_valid || out_ready. This combinational path runs from out_ready to in_ready. Throughput is still one per cycle. Squash and zeroing rules are unchanged.

## Test plan
- Reset then stream: hold reset for 3 cycles, then send in_valid = 1 with operands 0x1..0x8 and tid 0,1,2,3 cyclically, with out_ready = 1. Required: outputs appear in order one cycle later, one per cycle, with in_ready constantly 1.
- Backpressure: stream A, B, C and drop out_ready for 3 cycles. Required with SKID_EN: out holds A, skid holds B, in_ready = 0, and C is held by the source. On release, A, B, C come out in order with no loss or duplicate. Without SKID_EN, in_ready = 0 while A is held.
- Targeted squash: hold main = (tid 1, 0xAA) and skid = (tid 2, 0xBB) with out_ready = 0, then pulse flush_valid with flush_tid = 1. Required: next cycle out shows tid 2, 0xBB, and 0xAA is never re-presented.
- Same-cycle squash of input: send in_valid with tid 3, 0xCC while flush_valid = 1 and flush_tid = 3. Required: the input is accepted (in_ready = 1) and then discarded, leaving out_valid = 0 and out_ctrl = 0.
- Bubble zeroing: send one instruction with wb_ctrl = 2'b11 and mem_ctrl = 1, followed by idle cycles. Required: after it is consumed, out_valid = 0 and out_ctrl = 0, out_data0 = 0, out_data1 = 0.
- Reset mid-stall: with both entries full and out_ready = 0, assert reset for 1 cycle. Required: out_valid = 0 and all outputs 0 next cycle, and in_ready = 1 after deassertion.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID->EX pipeline register for the multithreaded CPU. Carries two
//            operands, packed control and thread ID under a valid/ready
//            handshake, with per-thread squash and zeroed bubbles.
// Option   : ID_EX_STAGE_SKID_EN
//              defined   -> two-entry skid buffer, in_ready is registered
//              undefined -> single register, in_ready = !out_valid || out_ready
// Ports    : clk, reset (sync, active-high)
//            in_valid/in_ready, in_data0/1, in_ctrl, in_tid   (decode side)
//            out_valid/out_ready, out_data0/1, out_ctrl, out_tid (execute side)
//            flush_valid, flush_tid                           (squash request)
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 26,
  parameter int TID_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TID_W-1:0]  in_tid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TID_W-1:0]  out_tid,
  input  logic              flush_valid,
  input  logic [TID_W-1:0]  flush_tid
);

  typedef struct packed {
    logic              valid;
    logic [TID_W-1:0]  tid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data0;
  } entry_t;

  // An empty slot is all zeros, so a bubble never carries stray control.
  localparam entry_t ENTRY_NONE = '0;

  entry_t main_q, main_d;
  entry_t in_e;
  logic   in_xfer;

  assign in_e    = {1'b1, in_tid, in_ctrl, in_data1, in_data0};
  assign in_xfer = in_valid && in_ready;

  // Drop an entry belonging to the squashed thread.
  function automatic entry_t squash(input entry_t e, input logic fv,
                                    input logic [TID_W-1:0] ft);
    if (fv && e.valid && (e.tid == ft))
      return ENTRY_NONE;
    return e;
  endfunction

`ifdef ID_EX_STAGE_SKID_EN
  entry_t skid_q, skid_d;

  // Registered ready: only depends on skid occupancy (and reset).
  assign in_ready = !skid_q.valid && !reset;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!main_q.valid || out_ready) begin
      if (skid_q.valid) begin
        main_d = skid_q;
        skid_d = in_xfer ? in_e : ENTRY_NONE;
      end else begin
        main_d = in_xfer ? in_e : ENTRY_NONE;
        skid_d = ENTRY_NONE;
      end
    end else if (in_xfer) begin
      skid_d = in_e;
    end
    main_d = squash(main_d, flush_valid, flush_tid);
    skid_d = squash(skid_d, flush_valid, flush_tid);
    // Keep the skid behind main: a hole in main after squash is refilled.
    if (!main_d.valid && skid_d.valid) begin
      main_d = skid_d;
      skid_d = ENTRY_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= ENTRY_NONE;
      skid_q <= ENTRY_NONE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
`else
  // Combinational path from out_ready keeps full throughput with one slot.
  assign in_ready = (!main_q.valid || out_ready) && !reset;

  always_comb begin
    main_d = main_q;
    if (!main_q.valid || out_ready)
      main_d = in_xfer ? in_e : ENTRY_NONE;
    main_d = squash(main_d, flush_valid, flush_tid);
  end

  always_ff @(posedge clk) begin
    if (reset)
      main_q <= ENTRY_NONE;
    else
      main_q <= main_d;
  end
`endif

  assign out_valid = main_q.valid;
  assign out_data0 = main_q.data0;
  assign out_data1 = main_q.data1;
  assign out_ctrl  = main_q.ctrl;
  assign out_tid   = main_q.tid;

endmodule
`default_nettype wire
